mm2s_stride_dma: RTL

MM2S_STRIDE_DMA -- requirements
Module: mm2s_stride_dma

---
 rtl/mm2s_stride_dma.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mm2s_stride_dma.sv
// mm2s_stride_dma: memory-to-stream DMA that reads LENGTH words at ADDR, ADDR+STRIDE, ... into a stream.
// Latency: address goes out two cycles after START; each beat is buffered one cycle before it can leave.
// Backpressure: reads are issued only while the outstanding count plus buffered beats stay below FIFO_DEPTH.
//
// Optional build macro: MM2S_DONE_IRQ_EN adds the irq output.
// Ports:
//   clk, rst_n                    single clock, asynchronous active-low reset
//   i_ps_w*/o_ps_w*               register write: word index, data, valid, ready (tied 1), response pulse
//   i_ps_ar*/o_ps_r*              register read: word index, valid; rvalid mirrors arvalid, rdata combinational
//   o_mem_ar*/i_mem_r*/i_mem_arready/o_mem_rready   memory read-address and read-data channels
//   o_dout_data/valid/last, i_dout_ready            output stream
//   irq                           done/error interrupt, present only with MM2S_DONE_IRQ_EN

// Small synchronous FIFO with occupancy count and flush. The head word is shown
// combinationally and holds until popped.
module mm2s_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_pop_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && (r_count != C_FULL);
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_pop_dat = r_mem[r_rptr];
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
        end
    end
endmodule

module mm2s_stride_dma #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH      = 256,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // register interface
    input  logic [7:0]            i_ps_waddr,
    input  logic [31:0]           i_ps_wdata,
    input  logic                  i_ps_wvalid,
    output logic                  o_ps_wready,
    output logic                  o_ps_wresp,
    input  logic [7:0]            i_ps_araddr,
    input  logic                  i_ps_arvalid,
    output logic                  o_ps_rvalid,
    output logic [31:0]           o_ps_rdata,
    // memory read channel
    output logic [ADDR_WIDTH-1:0] o_mem_araddr,
    output logic                  o_mem_arvalid,
    input  logic                  i_mem_arready,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_rvalid,
    output logic                  o_mem_rready,
    // output stream
    output logic [DATA_WIDTH-1:0] o_dout_data,
    output logic                  o_dout_valid,
    input  logic                  i_dout_ready,
    output logic                  o_dout_last
`ifdef MM2S_DONE_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_ABORT} state_t;

    state_t                r_state;
    // programmable registers
    logic [31:0]           r_addr;
    logic                  r_addr_valid;
    logic [3:0]            r_error;
    logic [31:0]           r_length;
    logic [31:0]           r_stride;
    logic                  r_done;
    logic                  r_wresp;
    // per-transfer state, latched at START
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_stride_l;
    logic [31:0]           r_len_l;
    logic [31:0]           r_issued;
    logic [31:0]           r_outstanding;
    logic [31:0]           r_pushed;
    logic                  r_arvalid;

    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic [DATA_WIDTH:0]   w_fifo_head;

    logic                  w_wr_start, w_wr_abort, w_start_ok, w_abort;
    logic                  w_ar_hs, w_rbeat, w_push, w_pop, w_last_pop, w_flush;
    logic                  w_push_last, w_credit_ok;
    logic [31:0]           w_out_next, w_iss_next, w_occ_next;
    logic [3:0]            w_err_set;

    assign w_wr_start = i_ps_wvalid && (i_ps_waddr == 8'd4) && i_ps_wdata[0];
    assign w_wr_abort = i_ps_wvalid && (i_ps_waddr == 8'd7) && i_ps_wdata[0];
    assign w_start_ok = w_wr_start && (r_state == S_IDLE) && r_addr_valid && (r_length != 32'd0);

    assign w_pop      = !w_fifo_empty && i_dout_ready;
    assign w_last_pop = (r_state == S_DRAIN) && w_pop && w_fifo_head[DATA_WIDTH];
    // A transfer whose final beat leaves in the same cycle as ABORT is treated as completed.
    assign w_abort    = w_wr_abort &&
                        ((r_state == S_FETCH) || ((r_state == S_DRAIN) && !w_last_pop));

    assign w_ar_hs    = r_arvalid && i_mem_arready;
    // Beats arriving while idle belong to reads from before a reset and are dropped.
    assign w_rbeat    = i_mem_rvalid && (r_state != S_IDLE) && (r_outstanding != 32'd0);
    assign w_push     = w_rbeat && ((r_state == S_FETCH) || (r_state == S_DRAIN)) && !w_abort;
    assign w_flush    = w_abort || (r_state == S_ABORT);
    assign w_push_last = (r_pushed == r_len_l - 32'd1);

    // Credit check on next-cycle values so arvalid can be registered yet issue back-to-back.
    assign w_out_next  = r_outstanding + 32'(w_ar_hs) - 32'(w_rbeat);
    assign w_iss_next  = r_issued + 32'(w_ar_hs);
    assign w_occ_next  = 32'(w_fifo_count) + 32'(w_push) - 32'(w_pop);
    assign w_credit_ok = (w_iss_next < r_len_l) &&
                         (w_out_next < 32'(MAX_OUTSTANDING)) &&
                         (({1'b0, w_out_next} + {1'b0, w_occ_next}) < 33'(FIFO_DEPTH));

    assign w_err_set[0] = i_ps_wvalid && (i_ps_waddr > 8'd7);
    assign w_err_set[1] = w_wr_start && (r_state == S_IDLE) && !r_addr_valid;
    assign w_err_set[2] = w_wr_start && (r_state == S_IDLE) && r_addr_valid && (r_length == 32'd0);
    assign w_err_set[3] = w_abort;

    mm2s_fifo #(.W(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_push_dat ({w_push_last, i_mem_rdata}),
        .i_pop      (w_pop),
        .o_pop_dat  (w_fifo_head),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    assign o_dout_valid  = !w_fifo_empty;
    assign o_dout_data   = w_fifo_head[DATA_WIDTH-1:0];
    assign o_dout_last   = !w_fifo_empty && w_fifo_head[DATA_WIDTH];
    // The address only advances on a handshake, so it is stable while arvalid waits.
    assign o_mem_araddr  = r_cur_addr;
    assign o_mem_arvalid = r_arvalid;
    assign o_mem_rready  = 1'b1;
    assign o_ps_wready   = 1'b1;
    assign o_ps_wresp    = r_wresp;
    assign o_ps_rvalid   = i_ps_arvalid;

    always_comb begin
        o_ps_rdata = 32'd0;
        case (i_ps_araddr)
            8'd0: o_ps_rdata = r_addr;
            8'd1: o_ps_rdata = {31'd0, r_addr_valid};
            8'd2: o_ps_rdata = {28'd0, r_error};
            8'd3: o_ps_rdata = r_length;
            8'd5: o_ps_rdata = r_stride;
            8'd6: o_ps_rdata = {29'd0, (r_state != S_IDLE), r_done, (r_state == S_IDLE)};
            default: o_ps_rdata = 32'd0;
        endcase
    end

    // Transfer FSM and its counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cur_addr    <= '0;
            r_stride_l    <= '0;
            r_len_l       <= 32'd0;
            r_issued      <= 32'd0;
            r_outstanding <= 32'd0;
            r_pushed      <= 32'd0;
            r_arvalid     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_cur_addr <= r_cur_addr + r_stride_l;
                r_issued   <= w_iss_next;
            end
            r_outstanding <= w_out_next;
            if (w_push) r_pushed <= r_pushed + 32'd1;
            r_arvalid <= (r_arvalid && !i_mem_arready) ||
                         ((r_state == S_FETCH) && !w_abort && w_credit_ok);
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= S_FETCH;
                        r_cur_addr <= r_addr[ADDR_WIDTH-1:0];
                        r_stride_l <= r_stride[ADDR_WIDTH-1:0];
                        r_len_l    <= r_length;
                        r_issued   <= 32'd0;
                        r_pushed   <= 32'd0;
                        r_done     <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_abort)                     r_state <= S_ABORT;
                    else if (w_iss_next == r_len_l)  r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_last_pop) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (w_abort) begin
                        r_state <= S_ABORT;
                    end
                end
                S_ABORT: begin
                    // Wait for the pending address and every accepted read to come back.
                    if ((r_outstanding == 32'd0) && !r_arvalid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= 32'd0;
            r_addr_valid <= 1'b0;
            r_error      <= 4'd0;
            r_length     <= 32'd0;
            r_stride     <= 32'd0;
            r_wresp      <= 1'b0;
        end else begin
            r_wresp <= i_ps_wvalid;
            if (i_ps_wvalid) begin
                case (i_ps_waddr)
                    8'd0: begin
                        r_addr       <= i_ps_wdata;
                        r_addr_valid <= 1'b1;
                    end
                    8'd3: r_length <= i_ps_wdata;
                    8'd5: r_stride <= i_ps_wdata;
                    default: ;
                endcase
            end
            r_error <= (((i_ps_wvalid && (i_ps_waddr == 8'd2)) ? 4'd0 : r_error)) | w_err_set;
        end
    end

`ifdef MM2S_DONE_IRQ_EN
    // Set events win over a same-cycle clear from a STATUS write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else if (w_last_pop || (w_err_set != 4'd0)) begin
            irq <= 1'b1;
        end else if (i_ps_wvalid && (i_ps_waddr == 8'd6)) begin
            irq <= 1'b0;
        end
    end
`endif
endmodule
